// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared state encodings, default timeout and counter width helper
package wb_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;
  localparam int DEFAULT_TIMEOUT = 255;
  function automatic int cnt_width(input int n);
    return n > 0 ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_bus_watchdog.sv
// bus_watchdog: counts unanswered strobed cycles and strobes timeout when the limit is reached
module bus_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic resp_i,
  output logic timeout_o
);
  localparam int W = cnt_width(TIMEOUT_CYCLES);
  logic [W-1:0] count;
  assign timeout_o = (TIMEOUT_CYCLES != 0) && active_i && !resp_i && (count == W'(TIMEOUT_CYCLES));
  always_ff @(posedge clk_i)
    count <= (!rst_ni || TIMEOUT_CYCLES == 0 || !active_i || resp_i || timeout_o) ? '0 : count + 1'b1;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone classic arbiter with cycle-lock grants and bus watchdog
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 1,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  arb_state_e state, state_n;
  logic last_grant, g0, g1, cyc_raw, stb_raw, timeout;
  assign g0 = state == ARB_GRANT0;
  assign g1 = state == ARB_GRANT1;
  assign cyc_raw = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign stb_raw = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .active_i (cyc_raw && stb_raw),
    .resp_i   (s_ack_i || s_err_i || s_rty_i),
    .timeout_o(timeout)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_n;
      if (state == ARB_IDLE && state_n != ARB_IDLE) last_grant <= state_n == ARB_GRANT1;
    end
  end
  always_comb begin
    state_n = ARB_IDLE;
    case (state)
      ARB_IDLE:   state_n = (m0_cyc_i && m1_cyc_i) ? ((FIXED_PRIORITY != 0 || last_grant) ? ARB_GRANT0 : ARB_GRANT1)
                          : m0_cyc_i ? ARB_GRANT0 : m1_cyc_i ? ARB_GRANT1 : ARB_IDLE;
      ARB_GRANT0: state_n = m0_cyc_i ? ARB_GRANT0 : ARB_IDLE;
      ARB_GRANT1: state_n = m1_cyc_i ? ARB_GRANT1 : ARB_IDLE;
      default:    state_n = ARB_IDLE;
    endcase
  end
  always_comb begin
    s_cyc_o   = cyc_raw && !timeout;
    s_stb_o   = stb_raw && !timeout;
    s_we_o    = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
    s_adr_o   = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_sel_o   = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    s_dat_o   = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    m0_dat_o  = g0 ? s_dat_i : '0;
    m0_ack_o  = g0 && s_ack_i;
    m0_err_o  = g0 && (s_err_i || timeout);
    m0_rty_o  = g0 && s_rty_i;
    m1_dat_o  = g1 ? s_dat_i : '0;
    m1_ack_o  = g1 && s_ack_i;
    m1_err_o  = g1 && (s_err_i || timeout);
    m1_rty_o  = g1 && s_rty_i;
    grant_o   = {g1, g0};
    timeout_o = timeout;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for a round-robin/watchdog instance and a fixed-priority/no-watchdog instance
module tb_wb_arbiter;
  logic clk = 1'b0, rst_n;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
  logic [3:0] m0_sel, m1_sel;
  logic s_ack, s_err, s_rty;
  logic [31:0] m0_rd, m1_rd, s_adr, s_wd, f_m0_rd, f_m1_rd, f_s_adr, f_s_wd;
  logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty, s_cyc, s_stb, s_we, timeout;
  logic f_m0_ack, f_m0_err, f_m0_rty, f_m1_ack, f_m1_err, f_m1_rty, f_s_cyc, f_s_stb, f_s_we, f_timeout;
  logic [3:0] s_sel, f_s_sel;
  logic [1:0] grant, f_grant;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel), .m0_dat_i(m0_dat),
    .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel), .m1_dat_i(m1_dat),
    .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel), .s_dat_o(s_wd),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .timeout_o(timeout)
  );
  wb_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(0)) dut_f (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel), .m0_dat_i(m0_dat),
    .m0_dat_o(f_m0_rd), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err), .m0_rty_o(f_m0_rty),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel), .m1_dat_i(m1_dat),
    .m1_dat_o(f_m1_rd), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err), .m1_rty_o(f_m1_rty),
    .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_we_o(f_s_we), .s_adr_o(f_s_adr), .s_sel_o(f_s_sel), .s_dat_o(f_s_wd),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(f_grant), .timeout_o(f_timeout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0; m0_cyc = 1; m1_cyc = 1; m0_stb = 0; m1_stb = 0; m0_we = 1; m1_we = 0;
    m0_adr = 32'h100; m1_adr = 32'h200; m0_sel = 4'h3; m1_sel = 4'hc;
    m0_dat = 32'hA0A0_0000; m1_dat = 32'hB1B1_0000; s_dat_i = 0; s_ack = 0; s_err = 0; s_rty = 0;
    tick(); tick();
    chk("rst_grant", grant, 0); chk("rst_scyc", s_cyc, 0); chk("rst_sadr", s_adr, 0);
    chk("rst_f_grant", f_grant, 0); chk("rst_m0_err", m0_err, 0);
    rst_n = 1; tick();
    chk("first_grant", grant, 2'b01); chk("first_sadr", s_adr, 32'h100); chk("first_ssel", s_sel, 4'h3);
    chk("first_swe", s_we, 1); chk("first_sdat", s_wd, 32'hA0A0_0000); chk("first_f_grant", f_grant, 2'b01);
    m0_cyc = 0; m1_cyc = 0; tick();
    chk("release_idle", grant, 0);
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_1000; tick();
    chk("single_grant", grant, 2'b10); chk("single_sadr", s_adr, 32'h0000_1000); chk("single_sstb", s_stb, 1);
    chk("single_noack", m1_ack, 0);
    tick(); tick(); tick();
    s_dat_i = 32'hDEAD_BEEF; s_ack = 1; #1;
    chk("single_rd", m1_rd, 32'hDEAD_BEEF); chk("single_ack", m1_ack, 1); chk("single_m0_ack", m0_ack, 0);
    chk("single_m0_rd", m0_rd, 0); chk("single_timeout", timeout, 0);
    s_ack = 0; m1_cyc = 0; m1_stb = 0; tick();
    chk("single_idle", grant, 0);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1; tick();
    chk("rr_1", grant, 2'b01); chk("rr_1_m0_ack", m0_ack, 1); chk("rr_1_m1_ack", m1_ack, 0); chk("fp_1", f_grant, 2'b01);
    m0_cyc = 0; m0_stb = 0; tick();
    chk("rr_2", grant, 0); chk("fp_2", f_grant, 0);
    m0_cyc = 1; m0_stb = 1; tick();
    chk("rr_3", grant, 2'b10); chk("rr_3_m1_ack", m1_ack, 1); chk("rr_3_m0_ack", m0_ack, 0); chk("fp_3", f_grant, 2'b01);
    m1_cyc = 0; m1_stb = 0; tick();
    chk("rr_4", grant, 0); chk("fp_4", f_grant, 2'b01);
    m1_cyc = 1; m1_stb = 1; tick();
    chk("rr_5", grant, 2'b01); chk("fp_5", f_grant, 2'b01);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; tick();
    chk("rr_done", grant, 0);
    m0_cyc = 1; m0_stb = 1; tick();
    chk("wd_c1_err", m0_err, 0); chk("wd_c1_stb", s_stb, 1);
    tick(); tick(); tick();
    chk("wd_c4_timeout", timeout, 0); chk("wd_c4_err", m0_err, 0);
    tick();
    chk("wd_c5_err", m0_err, 1); chk("wd_c5_timeout", timeout, 1); chk("wd_c5_stb", s_stb, 0);
    chk("wd_c5_cyc", s_cyc, 0); chk("wd_c5_m1_err", m1_err, 0);
    chk("wd_f_timeout", f_timeout, 0); chk("wd_f_stb", f_s_stb, 1); chk("wd_f_err", f_m0_err, 0);
    tick();
    chk("wd_c6_timeout", timeout, 0); chk("wd_c6_stb", s_stb, 1);
    tick(); tick(); tick(); tick();
    s_ack = 1; #1;
    chk("wd_race_ack", m0_ack, 1); chk("wd_race_err", m0_err, 0); chk("wd_race_timeout", timeout, 0);
    chk("wd_race_stb", s_stb, 1);
    s_ack = 0; m0_cyc = 0; m0_stb = 0; tick();
    m0_cyc = 1; m0_stb = 1; tick();
    m1_cyc = 1; m1_stb = 1; s_ack = 1; #1;
    chk("hold_sadr", s_adr, 32'h100); chk("hold_m1_ack", m1_ack, 0); chk("hold_m0_ack", m0_ack, 1);
    m0_cyc = 0; m0_stb = 0; s_ack = 0; tick();
    s_ack = 1; #1;
    chk("abort_m0_ack", m0_ack, 0); chk("abort_m1_ack", m1_ack, 0); chk("abort_grant", grant, 0);
    chk("abort_f_m1_ack", f_m1_ack, 0);
    s_ack = 0; tick();
    chk("mid_pre_grant", grant, 2'b10); chk("mid_pre_f_grant", f_grant, 2'b10);
    rst_n = 0; tick();
    chk("mid_rst_scyc", s_cyc, 0); chk("mid_rst_grant", grant, 0); chk("mid_rst_f_scyc", f_s_cyc, 0);
    s_ack = 1; #1;
    chk("mid_rst_late_ack", m1_ack, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the shared system bus.
- Master 0 is the cpu (fetch and load/store); master 1 is a secondary requester such as a DMA or debug port.
- Grants the bus per cycle-lock (cyc held = ownership held) with round-robin or fixed priority.
- Runs a bus watchdog that terminates hung slave accesses with err, so the cpu can trap instead of deadlocking.

Parameters:
- FIXED_PRIORITY, 0, 1 = master 0 always wins ties; 0 = round-robin on ties.
- TIMEOUT_CYCLES, 255, cycles a strobed access may wait for a response before forced err; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- mN_cyc_i  in  1  master N cycle (N = 0, 1; one port per master for every mN_ line)
- mN_stb_i  in  1  master N strobe
- mN_we_i  in  1  master N write enable
- mN_adr_i  in  32  master N address
- mN_sel_i  in  4  master N byte select
- mN_dat_i  in  32  master N write data
- mN_dat_o  out  32  read data to master N
- mN_ack_o  out  1  ack to master N
- mN_err_o  out  1  err to master N
- mN_rty_o  out  1  rty to master N
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave bus
- s_adr_o  out  32  to slave bus
- s_sel_o  out  4  to slave bus
- s_dat_o  out  32  to slave bus
- s_dat_i  in  32  from slave bus
- s_ack_i, s_err_i, s_rty_i  in  1 each  from slave bus
- grant_o  out  2  one-hot current owner (bit N = master N); 00 when idle
- timeout_o  out  1  pulses in the cycle a watchdog err is issued

Behaviour:
Reset (rst_ni low at a clk_i edge):
- State goes to IDLE, last_grant = 1 (so master 0 wins the first tie), watchdog count = 0.
- All outputs read 0 from the next cycle.
- Reset mid-transaction drops s_cyc_o/s_stb_o immediately. A slave response arriving afterwards is discarded.

State machine, registered:
- IDLE -> GRANT0 / GRANT1 on the next edge when a master has cyc_i high.
- Tie with FIXED_PRIORITY = 1: master 0 wins.
- Tie with FIXED_PRIORITY = 0: the master other than last_grant wins.
- Grant latency is 1 cycle from the cyc request to s_cyc_o.
- GRANTn -> IDLE on the edge where mn_cyc_i is low. This leaves one idle cycle between owners; no direct GRANT0 -> GRANT1 transition.
- last_grant updates on entry to GRANTn.

Routing, combinational from state:
- In GRANTn, the s_* outputs mirror master n's inputs.
- mn_dat_o = s_dat_i. mn_ack_o/err_o/rty_o mirror the slave response.
- The non-owner's ack/err/rty = 0 and its dat_o = 0.
- In IDLE all s_* outputs = 0 and all slave responses are ignored.

Watchdog (counter width $clog2(TIMEOUT_CYCLES+1)):
- Increments each cycle that s_stb_o = 1 with no ack/err/rty.
- Clears on any response, on s_stb_o = 0, and on leaving GRANTn.
- When count == TIMEOUT_CYCLES, in that same cycle:
  - owner err_o = 1 and timeout_o = 1;
  - s_cyc_o and s_stb_o are masked to 0;
  - the counter clears on the next edge.
- Genuine response in the timeout cycle: the response wins. It is routed unchanged, with no err and no timeout_o.
- TIMEOUT_CYCLES = 0: counter held at 0, timeout never fires.

Other boundaries:
- Owner drops cyc with no response (abort): release to IDLE; a late response is not forwarded.
- A master requesting while the other owns the bus waits with no response; its cyc is held off-bus.
- Owner asserts cyc without stb: grant is held and the counter stays 0.

Decomposition:
- Shared package/header (alongside params.vh): arbiter state encodings ARB_IDLE = 2'd0, ARB_GRANT0 = 2'd1, ARB_GRANT1 = 2'd2, and the default timeout constant.
- One natural sub-module: bus_watchdog (counter, compare, clear logic; outputs the timeout strobe). The arbiter FSM and muxing stay in wb_arbiter.

Test Plan:
- Reset: rst_ni = 0 for 2 cycles with both cyc high -> all outputs 0, grant_o = 00. After release: grant_o = 01 next cycle, s_adr_o = m0_adr_i.
- Single master: m1 read at adr 0x0000_1000, slave acks with 0xDEAD_BEEF after 3 cycles -> m1_dat_o = 0xDEAD_BEEF with m1_ack_o in the same cycle; m0_ack_o stays 0.
- Round-robin (FIXED_PRIORITY = 0): both cyc held continuously, each owner drops cyc after one ack -> grant_o sequence 01, 00, 10, 00, 01, with one idle cycle between owners.
- Fixed priority (FIXED_PRIORITY = 1): both requesting after every release -> grant_o always 01; m1 is never granted while m0 keeps requesting.
- Watchdog (TIMEOUT_CYCLES = 4): m0 strobes, slave silent -> in the 5th strobed cycle m0_err_o = 1, timeout_o = 1, s_stb_o = 0; with a slave ack in that same cycle instead -> ack forwarded, no err.
- Abort and reset mid-access: m0 drops cyc before ack, slave acks one cycle later -> no ack to either master. Separately, rst_ni low during GRANT1 -> s_cyc_o = 0 on the next cycle, grant_o = 00.
